// File: rtl/packet_switch_n.sv
// Parametrised 1-to-NUM_PORTS byte-stream packet switch with per-port store-and-forward FIFOs.
// Packets are routed by DA match on byte 0; runts, unmatched and overflowing packets are dropped.
module packet_switch_n #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_status,
  input  logic [DATA_W-1:0]             data,
  input  logic                          mem_en,
  input  logic                          mem_rd_wr,
  input  logic [ADDR_W-1:0]             mem_add,
  input  logic [DATA_W-1:0]             mem_data,
  output logic [DATA_W-1:0]             mem_rdata,
  output logic [NUM_PORTS*DATA_W-1:0]   port_data,
  output logic [NUM_PORTS-1:0]          ready,
  input  logic [NUM_PORTS-1:0]          read
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int PIW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, FWD, DROP, DROP_SILENT} state_e;

  state_e              state_q;
  logic [PIW-1:0]      port_q;
  logic [1:0]          cnt_q;
  logic [DATA_W-1:0]   da_q   [NUM_PORTS];
  logic [DATA_W-1:0]   acc_q  [NUM_PORTS];
  logic [DATA_W-1:0]   drop_q;
  logic [DATA_W-1:0]   mem_rdata_q;
  logic [PW-1:0]       wr_ptr_q     [NUM_PORTS];
  logic [PW-1:0]       commit_ptr_q [NUM_PORTS];
  logic [PW-1:0]       rd_ptr       [NUM_PORTS];

  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] wr_en;
  logic [NUM_PORTS-1:0] commit_en;
  logic                 match_found;
  logic [PIW-1:0]       match_idx;
  logic                 drop_inc;
  logic [DATA_W-1:0]    rd_val;

  // Descending scan so the lowest matching port index wins.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (data == da_q[i]) begin
        match_found = 1'b1;
        match_idx   = PIW'(i);
      end
    end
  end

  always_comb begin
    drop_inc = 1'b0;
    case (state_q)
      IDLE:    drop_inc = data_status && (!match_found || full[match_idx]);
      FWD:     drop_inc = data_status ? full[port_q] : (cnt_q != 2'd3);
      default: drop_inc = 1'b0;
    endcase
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (mem_add == ADDR_W'(i))             rd_val = da_q[i];
      if (mem_add == ADDR_W'(NUM_PORTS + i)) rd_val = acc_q[i];
    end
    if (mem_add == ADDR_W'(2 * NUM_PORTS)) rd_val = drop_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rdata_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) da_q[i] <= '0;
    end else if (mem_en) begin
      if (mem_rd_wr) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (mem_add == ADDR_W'(i)) da_q[i] <= mem_data;
        end
      end else begin
        mem_rdata_q <= rd_val;
      end
    end
  end

  assign mem_rdata = mem_rdata_q;

  // Ingress FSM; a reset that lands mid-packet parks the tail in DROP_SILENT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= data_status ? DROP_SILENT : IDLE;
      port_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        wr_ptr_q[i]     <= '0;
        commit_ptr_q[i] <= '0;
        acc_q[i]        <= '0;
      end
    end else begin
      if (drop_inc && (drop_q != {DATA_W{1'b1}})) drop_q <= drop_q + 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (commit_en[i]) begin
          commit_ptr_q[i] <= wr_ptr_q[i];
          acc_q[i]        <= acc_q[i] + 1'b1;
        end
      end
      if ((state_q == FWD) && drop_inc) wr_ptr_q[port_q] <= commit_ptr_q[port_q];
      case (state_q)
        IDLE: begin
          if (data_status) begin
            if (drop_inc) begin
              state_q <= DROP;
            end else begin
              state_q <= FWD;
              port_q  <= match_idx;
              cnt_q   <= 2'd1;
            end
          end
        end
        FWD: begin
          if (drop_inc)               state_q <= data_status ? DROP : IDLE;
          else if (!data_status)      state_q <= IDLE;
          else if (cnt_q != 2'd3)     cnt_q   <= cnt_q + 2'd1;
        end
        default: begin
          if (!data_status) state_q <= IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] pdata_q;
    logic [PW-1:0]     rd_ptr_q;
    logic              ready_q;
    logic              pop;
    logic [PW-1:0]     commit_nx;
    logic [PW-1:0]     rd_nx;

    assign full[gi]      = (wr_ptr_q[gi] - rd_ptr_q) == PW'(FIFO_DEPTH);
    assign wr_en[gi]     = data_status && !full[gi] &&
                           (((state_q == IDLE) && match_found && (match_idx == PIW'(gi))) ||
                            ((state_q == FWD) && (port_q == PIW'(gi))));
    assign commit_en[gi] = !data_status && (state_q == FWD) && (port_q == PIW'(gi)) &&
                           (cnt_q == 2'd3);
    assign pop           = read[gi] && ready_q;
    // ready tracks next-state pointers so it never lags a pop of the last byte.
    assign commit_nx     = commit_en[gi] ? wr_ptr_q[gi] : commit_ptr_q[gi];
    assign rd_nx         = rd_ptr_q + PW'(pop);

    always_ff @(posedge clk) begin
      if (wr_en[gi]) fifo_mem[wr_ptr_q[gi][AW-1:0]] <= data;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_ptr_q <= '0;
        pdata_q  <= '0;
        ready_q  <= 1'b0;
      end else begin
        if (pop) begin
          pdata_q  <= fifo_mem[rd_ptr_q[AW-1:0]];
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        ready_q <= (commit_nx != rd_nx);
      end
    end

    assign rd_ptr[gi]                        = rd_ptr_q;
    assign ready[gi]                         = ready_q;
    assign port_data[gi*DATA_W +: DATA_W]    = pdata_q;
  end

endmodule

// File: tb/tb_packet_switch_n.sv
// Scoreboard bench for packet_switch_n: stimulus queues expected egress bytes and register
// reads, a free-running monitor pops and compares them as the DUT produces them.
module tb_packet_switch_n;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int FD = 8;
  localparam int AWD = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              data_status;
  logic [DW-1:0]     data;
  logic              mem_en;
  logic              mem_rd_wr;
  logic [AWD-1:0]    mem_add;
  logic [DW-1:0]     mem_data;
  logic [DW-1:0]     mem_rdata;
  logic [NP*DW-1:0]  port_data;
  logic [NP-1:0]     ready;
  logic [NP-1:0]     read;

  logic [NP-1:0]     drain_en;
  logic [7:0]        exp_q [NP][$];
  logic [7:0]        reg_q [$];
  logic [7:0]        pkt   [$];
  int                n_vec  = 0;
  int                n_miss = 0;

  packet_switch_n #(.NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(FD), .ADDR_W(AWD)) dut (
    .clk(clk), .reset(reset), .data_status(data_status), .data(data),
    .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_add(mem_add), .mem_data(mem_data),
    .mem_rdata(mem_rdata), .port_data(port_data), .ready(ready), .read(read)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endfunction

  function automatic void fail_line(string name, logic [31:0] act);
    n_vec++;
    n_miss++;
    $display("FAIL %s: got 0x%0h expected nothing", name, act);
  endfunction

  function automatic int pending();
    int s = reg_q.size();
    for (int i = 0; i < NP; i++) s += exp_q[i].size();
    return s;
  endfunction

  // Egress drain: request a pop on every enabled port that shows ready.
  initial begin
    read = '0;
    forever begin
      @(negedge clk);
      read = drain_en & ready;
    end
  end

  // Monitor: capture requests before the edge, compare outputs just after it.
  initial begin
    logic       rd_seen;
    logic [NP-1:0] pop_seen;
    forever begin
      @(negedge clk);
      #2;
      rd_seen  = mem_en && !mem_rd_wr && !reset;
      pop_seen = read & ready & {NP{!reset}};
      @(posedge clk);
      #1;
      if (rd_seen) begin
        if (reg_q.size() == 0) fail_line("reg_read_unexpected", 32'(mem_rdata));
        else chk("reg_read", 32'(mem_rdata), 32'(reg_q.pop_front()));
      end
      for (int i = 0; i < NP; i++) begin
        if (pop_seen[i]) begin
          if (exp_q[i].size() == 0) fail_line($sformatf("egress_unexpected_p%0d", i), 32'(port_data[i*DW +: DW]));
          else chk($sformatf("egress_p%0d", i), 32'(port_data[i*DW +: DW]), 32'(exp_q[i].pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic flush();
    for (int i = 0; i < NP; i++) exp_q[i].delete();
    reg_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush();
    tick();
    reset = 1'b0;
  endtask

  task automatic wr_reg(input int a, input int d);
    mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = 8'(a); mem_data = 8'(d);
    tick();
    mem_en = 1'b0; mem_rd_wr = 1'b0;
  endtask

  task automatic rd_reg(input int a, input int e);
    mem_en = 1'b1; mem_rd_wr = 1'b0; mem_add = 8'(a);
    reg_q.push_back(8'(e));
    tick();
    mem_en = 1'b0;
  endtask

  task automatic cfg();
    wr_reg(0, 8'h10); wr_reg(1, 8'h20); wr_reg(2, 8'h30); wr_reg(3, 8'h40);
  endtask

  task automatic mk(input int da, input int len);
    pkt.delete();
    pkt.push_back(8'(da));
    for (int k = 1; k < len; k++) pkt.push_back(8'(da + 7 * k + 1));
  endtask

  // Send pkt; port<0 means the packet must be dropped. Optionally check ready stays 0.
  task automatic send(input int port, input bit chk_rdy);
    if (port >= 0) foreach (pkt[k]) exp_q[port].push_back(pkt[k]);
    foreach (pkt[k]) begin
      if (chk_rdy) chk("ready_during_pkt", 32'(ready), 32'h0);
      data_status = 1'b1;
      data        = pkt[k];
      tick();
    end
    if (chk_rdy) chk("ready_before_end", 32'(ready), 32'h0);
    data_status = 1'b0;
    tick();
  endtask

  task automatic drain_wait();
    drain_en = '1;
    for (int c = 0; c < 80; c++) begin
      if (pending() == 0) break;
      tick();
    end
    if (pending() != 0) fail_line("drain_timeout", 32'(pending()));
    tick(); tick();
    chk("ready_after_drain", 32'(ready), 32'h0);
  endtask

  initial begin
    reset = 1'b1; data_status = 1'b0; data = '0;
    mem_en = 1'b0; mem_rd_wr = 1'b0; mem_add = '0; mem_data = '0;
    drain_en = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_port_data", port_data, 32'h0);
    chk("reset_mem_rdata", 32'(mem_rdata), 32'h0);
    rd_reg(8, 0);

    // 1: 5-byte packet to port 2, invisible until the last byte is in.
    cfg();
    mk(8'h30, 5);
    send(2, 1'b1);
    chk("t1_ready_after_commit", 32'(ready), 32'h4);
    rd_reg(6, 1);
    drain_wait();
    rd_reg(4, 0);

    // 2: unmatched DA dropped, back-to-back good packet delivered.
    do_reset(); cfg();
    drain_en = '1;
    mk(8'h55, 4); send(-1, 1'b0);
    mk(8'h10, 6); send(0, 1'b0);
    drain_wait();
    rd_reg(8, 1);
    rd_reg(4, 1);

    // 3: overflow drop, then a 6-byte packet and an exactly-FIFO_DEPTH packet.
    do_reset(); cfg();
    drain_en = '0;
    mk(8'h10, 10); send(-1, 1'b1);
    chk("t3_ready_after_overflow", 32'(ready), 32'h0);
    rd_reg(8, 1);
    mk(8'h10, 6); send(0, 1'b0);
    chk("t3_ready_p0", 32'(ready), 32'h1);
    drain_wait();
    rd_reg(4, 1);
    mk(8'h20, FD); send(1, 1'b0);
    drain_wait();
    rd_reg(5, 1);
    rd_reg(8, 1);

    // 4: runt drop; DA write in the same cycle as the first byte uses the old DA.
    do_reset();
    wr_reg(0, 8'h10); wr_reg(1, 8'h21); wr_reg(2, 8'h30); wr_reg(3, 8'h40);
    drain_en = '1;
    mk(8'h21, 2); send(-1, 1'b0);
    rd_reg(8, 1);
    mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = 8'd1; mem_data = 8'h20;
    data_status = 1'b1; data = 8'h20;
    tick();
    mem_en = 1'b0; mem_rd_wr = 1'b0;
    data = 8'h33; tick();
    data = 8'h44; tick();
    data_status = 1'b0; tick();
    rd_reg(8, 2);
    rd_reg(1, 8'h20);
    mk(8'h20, 3); send(1, 1'b0);
    drain_wait();
    rd_reg(5, 1);

    // 5: reset on byte 3 of an 8-byte packet with data_status held.
    do_reset(); cfg();
    drain_en = '0;
    mk(8'h40, 4); send(3, 1'b0);
    chk("t5_ready_p3", 32'(ready), 32'h8);
    data_status = 1'b1;
    data = 8'h10; tick();
    data = 8'h11; tick();
    data = 8'h12; reset = 1'b1; flush(); tick();
    reset = 1'b0;
    for (int k = 3; k < 8; k++) begin
      data = 8'(8'h10 + k);
      tick();
    end
    data_status = 1'b0; tick();
    chk("t5_ready_cleared", 32'(ready), 32'h0);
    chk("t5_port_data_cleared", port_data, 32'h0);
    rd_reg(7, 0);
    rd_reg(8, 0);
    rd_reg(0, 0);
    cfg();
    mk(8'h20, 4); send(1, 1'b0);
    drain_wait();
    rd_reg(5, 1);
    rd_reg(8, 0);

    // 6: unmapped reads, ignored RO/unmapped writes, saturating drop counter.
    do_reset(); cfg();
    rd_reg(2 * NP + 5, 0);
    wr_reg(NP, 8'h77);
    rd_reg(NP, 0);
    wr_reg(2 * NP + 5, 8'h55);
    rd_reg(2 * NP + 5, 0);
    rd_reg(2, 8'h30);
    for (int k = 0; k < 300; k++) begin
      data_status = 1'b1; data = 8'h55; tick();
      data_status = 1'b0; tick();
    end
    rd_reg(2 * NP, 8'hFF);
    tick();
    chk("t6_rdata_hold", 32'(mem_rdata), 32'hFF);

    drain_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
